// File: rtl/misr_resp_compactor.sv
// Response compactor: folds accepted W-bit vectors into a Galois MISR and compares
// the final signature with a latched expected value. Optional macro: MISR_XMASK_EN.
module misr_resp_compactor #(
    parameter int unsigned   W    = 8,
    parameter logic [W-1:0]  POLY = W'(32'h1D),
    parameter logic [W-1:0]  SEED = '0,
    parameter int unsigned   CW   = 16
) (
    input  logic          C,
    input  logic          RN,
    input  logic          START,
    input  logic          ABRT,
    input  logic [CW-1:0] LEN,
    input  logic [W-1:0]  EXP,
    input  logic          IN_VLD,
    input  logic [W-1:0]  IN_D,
`ifdef MISR_XMASK_EN
    input  logic [W-1:0]  IN_MASK,
`endif
    output logic          IN_RDY,
    output logic [W-1:0]  SIG,
    output logic [CW-1:0] CNT,
    output logic          BUSY,
    output logic          DONE,
    output logic          PASS
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_sig;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_len;
    logic [W-1:0]  r_exp;
    logic          r_rdy;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;

    logic [W-1:0]  w_din;
    logic [W-1:0]  w_fold;
    logic          w_beat;
    logic          w_last;

`ifdef MISR_XMASK_EN
    assign w_din = IN_D & ~IN_MASK;
`else
    assign w_din = IN_D;
`endif

    // Galois shift: MSB leaves and feeds back through the polynomial taps
    assign w_fold = {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : '0) ^ w_din;
    assign w_beat = IN_VLD & r_rdy;
    assign w_last = (r_cnt == (r_len - CW'(1)));

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_sig   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_exp   <= '0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (ABRT) begin
            // SIG/CNT are kept for debug; any beat this cycle is dropped
            r_state <= S_IDLE;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_sig <= SEED;
                        r_cnt <= '0;
                        r_len <= LEN;
                        r_exp <= EXP;
                        if (LEN != '0) begin
                            r_state <= S_RUN;
                            r_rdy   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_rdy   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (SEED == EXP);
                        end
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        r_sig <= w_fold;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_rdy   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_fold == r_exp);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign IN_RDY = r_rdy;
    assign SIG    = r_sig;
    assign CNT    = r_cnt;
    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign PASS   = r_pass;

endmodule
